// File: rtl/hello_world_qsys_switch_debounce_pkg.sv
// Shared constants and FSM state encoding for the switch conditioning block.
// The default debounce window is 10 ms of the 50 MHz system clock.
package hello_world_qsys_switch_debounce_pkg;

  localparam int CLK_FREQ_HZ             = 50_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEFAULT_CNT_W           = 24;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SETTLING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/hello_world_qsys_debounce_bit.sv
// One switch bit: 2-FF synchroniser, then a settle counter that accepts a new level
// only after DEBOUNCE_CYCLES consecutive edges of disagreement with the clean level.
module hello_world_qsys_debounce_bit
  import hello_world_qsys_switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic clean_out,
  output logic changed_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             clean_q, clean_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  deb_state_e       state_q, state_d;

  always_comb begin
    s1_d      = raw_in;
    s2_d      = s1_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    cnt_d     = cnt_q;
    state_d   = state_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s2_q != clean_q) begin
          // A one-cycle window would be satisfied by this very edge.
          if (CNT_LAST == '0) begin
            clean_d   = s2_q;
            changed_d = 1'b1;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = ST_SETTLING;
          end
        end
      end
      ST_SETTLING: begin
        if (s2_q == clean_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          clean_d   = s2_q;
          changed_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign clean_out   = clean_q;
  assign changed_out = changed_q;

endmodule

// File: rtl/hello_world_qsys_switch_debounce.sv
// Conditions raw board switches for the switch PIO in_port: per-bit sync + debounce,
// with a registered one-cycle change strobe per bit for edge capture or interrupts.
module hello_world_qsys_switch_debounce
  import hello_world_qsys_switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_clean,
  output logic [WIDTH-1:0] switch_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    hello_world_qsys_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk         (clk),
      .reset       (reset),
      .raw_in      (switch_raw[i]),
      .clean_out   (switch_clean[i]),
      .changed_out (switch_changed[i])
    );
  end

endmodule

// File: tb/tb_hello_world_qsys_switch_debounce.sv
// Bench for the switch debounce block with a 4-cycle window: directed scenarios, then
// random switch activity, each edge compared against a run-length reference model.
module tb_hello_world_qsys_switch_debounce;

  localparam int WIDTH = 2;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] switch_raw;
  logic [WIDTH-1:0] switch_clean;
  logic [WIDTH-1:0] switch_changed;

  int checks = 0;
  int errors = 0;

  // Reference: the clean level flips on the DEB-th consecutive edge where the
  // twice-delayed raw level disagrees with it.
  logic [WIDTH-1:0] m_d1, m_d2, m_clean, m_chg;
  int               m_run [WIDTH];
  logic [WIDTH-1:0] prev_chg;
  int               pulses [WIDTH];
  int               both_pulses;

  hello_world_qsys_switch_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .switch_raw     (switch_raw),
    .switch_clean   (switch_clean),
    .switch_changed (switch_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [WIDTH-1:0] raw);
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_clean = '0; m_chg = '0;
      for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
    end else begin
      m_chg = '0;
      for (int b = 0; b < WIDTH; b++) begin
        if (m_d2[b] != m_clean[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_clean[b] = ~m_clean[b];
            m_chg[b]   = 1'b1;
            m_run[b]   = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
  endtask

  task automatic step(input logic rst, input logic [WIDTH-1:0] raw);
    reset      = rst;
    switch_raw = raw;
    @(posedge clk);
    model_edge(rst, raw);
    #1;
    chk("clean", switch_clean, m_clean);
    chk("changed", switch_changed, m_chg);
    chk("no_back_to_back", switch_changed & prev_chg, '0);
    prev_chg = switch_changed;
    for (int b = 0; b < WIDTH; b++) pulses[b] += int'(switch_changed[b]);
    if (switch_changed == 2'b11) both_pulses++;
  endtask

  task automatic clear_counts();
    for (int b = 0; b < WIDTH; b++) pulses[b] = 0;
    both_pulses = 0;
  endtask

  task automatic hold(input logic [WIDTH-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(1'b0, raw);
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    int               len;
    logic [8:0]       chatter;
    prev_chg = '0;
    m_d1 = '0; m_d2 = '0; m_clean = '0; m_chg = '0;
    for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
    clear_counts();

    // Reset held with both switches on: outputs stay low throughout.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11);
      chk("rst_clean", switch_clean, 2'b00);
      chk("rst_changed", switch_changed, 2'b00);
    end
    clear_counts();
    hold(2'b11, 10);
    chk("post_rst_clean", switch_clean, 2'b11);
    chk_int("post_rst_both_pulses", both_pulses, 1);

    // Clean step on bit 0 only.
    hold(2'b00, 10);
    clear_counts();
    hold(2'b01, 10);
    chk("step_clean", switch_clean, 2'b01);
    chk_int("step_pulses0", pulses[0], 1);
    chk_int("step_pulses1", pulses[1], 0);

    // Glitches on bit 1: 3 cycles rejected, 4 cycles accepted and undone.
    hold(2'b00, 10);
    clear_counts();
    hold(2'b10, 3);
    hold(2'b00, 10);
    chk("glitch3_clean", switch_clean, 2'b00);
    chk_int("glitch3_pulses1", pulses[1], 0);
    clear_counts();
    hold(2'b10, 4);
    hold(2'b00, 12);
    chk("glitch4_clean", switch_clean, 2'b00);
    chk_int("glitch4_pulses1", pulses[1], 2);

    // Chatter on bit 0: only the closing run of four 1s counts.
    clear_counts();
    chatter = 9'b111101101;
    for (int i = 0; i < 9; i++) step(1'b0, {1'b0, chatter[i]});
    hold(2'b01, 8);
    chk("chatter_clean", switch_clean, 2'b01);
    chk_int("chatter_pulses0", pulses[0], 1);

    // Reset in the middle of a settle restarts synchronisation from scratch.
    hold(2'b00, 10);
    hold(2'b01, 4);
    step(1'b1, 2'b01);
    chk("midrst_clean", switch_clean, 2'b00);
    clear_counts();
    hold(2'b01, 10);
    chk("midrst_after", switch_clean, 2'b01);
    chk_int("midrst_pulses0", pulses[0], 1);

    // Both bits change together.
    hold(2'b00, 10);
    clear_counts();
    hold(2'b11, 10);
    chk_int("simul_both_pulses", both_pulses, 1);
    chk_int("simul_pulses0", pulses[0], 1);

    // Random switch activity with occasional resets.
    for (int i = 0; i < 120; i++) begin
      rv  = WIDTH'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 29) == 0) step(1'b1, rv);
      hold(rv, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
